mem_stage: RTL
==============

# mem_stage

Memory-access stage of the 8-bit pipelined processor; consumes the EX/MEM bundle produced by the execute stage (`zeroOut`, `acOutValue`, `ulaJumpOut`, `rs`, `WRMem`, `WMMem`, `RMMem`, `NEQMem`, `JMem`, `JCMem`). It owns the data memory, resolves jumps and conditional jumps, and squashes wrong-path instructions. It also holds the MEM/WB pipeline register that feeds write-back.

## Interface
Parameters:
- `DEPTH`, 256, data memory words (8-bit each); address is `rsIn` modulo `DEPTH`.
- `FLUSH_CYCLES`, 2, bubbles inserted after a taken branch.

Ports:
- `clock` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `zeroIn` in 1: ALU zero flag from EX.
- `acIn` in 8: ALU/accumulator result; store data and write-back value.
- `ulaJumpIn` in 8: branch/jump target computed in EX.
- `rsIn` in 8: register operand; data memory address.
- `WRMem`, `WMMem`, `RMMem`, `NEQMem`, `JMem`, `JCMem` in 1 each: register write, memory write, memory read, branch-if-not-equal select, jump, conditional jump.
- `pcSrc` out 1: combinational; 1 selects `jumpTarget` as next PC.
- `jumpTarget` out 8: combinational; equals `ulaJumpIn`.
- `flush` out 1: kill IF/ID and ID/EX contents.
- `WRWb` out 1: registered register-write enable.
- `memToRegWb` out 1: registered; 1 selects `memDataWb` in WB.
- `memDataWb` out 8: registered load data.
- `acWb` out 8: registered ALU result.
- `rsWb` out 8: registered `rsIn`.

## Operation
- Bubble mask: `live = (flushCnt == 0)`. When `live=0`, `WRMem`, `WMMem`, `RMMem`, `JMem`, and `JCMem` are treated as 0.
- Branch decision: `cond = NEQMem ? ~zeroIn : zeroIn`.
- `taken = live & (JMem | (JCMem & cond))`.
- `pcSrc = taken`.
- `jumpTarget = ulaJumpIn`, always driven.
- Flush counter:
  - `taken` loads `flushCnt = FLUSH_CYCLES`.
  - Otherwise a nonzero count decrements by 1.
  - `flush = taken | (flushCnt != 0)`.
- Store: `live & WMMem` writes `acIn` to `mem[rsIn]` on the edge.
- Load: `live & RMMem` reads `mem[rsIn]`.
  - If `WMMem` and `RMMem` are both set, the read returns the pre-write (old) value.
- MEM/WB register (each edge):
  - `WRWb = live & WRMem`
  - `memToRegWb = live & RMMem`
  - `memDataWb = load value`, or 0 if no load
  - `acWb = acIn`
  - `rsWb = rsIn`
- Memory contents are not cleared by reset; contents are undefined until written.
- Memory addresses wrap modulo `DEPTH`. 8-bit values wrap with no saturation.

## Timing
- Reset values:
  - `flushCnt=0`, `WRWb=0`, `memToRegWb=0`, `memDataWb=0`, `acWb=0`, `rsWb=0`.
  - `pcSrc` and `flush` are therefore 0 unless branch inputs are asserted.
  - Reset wins over everything, including a concurrent `taken`.
- Load latency: 1 cycle (data valid in `memDataWb` the cycle after `RMMem`).
- Store visible to a load in the next cycle.
- Branch: `pcSrc` and `jumpTarget` are valid in the same cycle as the branch input. `flush` stays high that cycle plus `FLUSH_CYCLES` following cycles.
- A branch arriving while `flushCnt != 0` is ignored: no reload, no `pcSrc`.
- Reset during a flush clears `flushCnt` immediately, and the next cycle is live.

## Structure
- Shared package `cpu_pkg` (extend if present):
  - `DATA_W=8`, `ADDR_W=8`, `FLUSH_CYCLES` constant.
  - Control-bundle struct/typedef for {WR, WM, RM, NEQ, J, JC}.
- One sub-module `data_mem`: `DEPTH`×8 array with synchronous write and combinational read. Old-data-on-collision semantics live in `mem_stage`'s registered capture.

## Test plan
- Reset: hold `reset` 2 cycles with random inputs -> all registered outputs 0, `flushCnt=0`. Release -> `flush=0`.
- Store then load:
  - Cycle 0: `WMMem=1`, `rsIn=8'h10`, `acIn=8'h5A`.
  - Cycle 1: `RMMem=1`, `WRMem=1`, `rsIn=8'h10`.
  - Cycle 2: `memDataWb=8'h5A`, `memToRegWb=1`, `WRWb=1`.
- Collision: `mem[8'h20]=8'h11`, then one cycle with `WMMem=RMMem=1`, `acIn=8'h22` -> `memDataWb=8'h11` next cycle; a later load returns `8'h22`.
- Jump:
  - `JMem=1`, `ulaJumpIn=8'd6` -> `pcSrc=1`, `jumpTarget=6`.
  - `flush` is high 3 cycles.
  - A `WMMem=1` or `JMem=1` presented in the 2 following cycles has no effect (memory unchanged, `pcSrc=0`).
- Conditional:
  - `JCMem=1`, `NEQMem=0`, `zeroIn=1` -> taken.
  - `NEQMem=1`, `zeroIn=1` -> not taken.
  - `NEQMem=1`, `zeroIn=0` -> taken.
- Reset mid-flush: assert `reset` one cycle after a taken jump -> `flush=0` the following cycle, and a store presented then commits.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit pipelined processor.
package cpu_pkg;

  localparam int DATA_W       = 8;
  localparam int ADDR_W       = 8;
  localparam int FLUSH_CYCLES = 2;

  // Control bundle carried from EX into MEM.
  typedef struct packed {
    logic wr;
    logic wm;
    logic rm;
    logic neq;
    logic j;
    logic jc;
  } ctrl_t;

  // Squash every side-effecting control bit of a wrong-path instruction.
  function automatic ctrl_t mask_bubble(ctrl_t c, logic live);
    ctrl_t m;
    m     = c;
    m.wr  = c.wr & live;
    m.wm  = c.wm & live;
    m.rm  = c.rm & live;
    m.j   = c.j  & live;
    m.jc  = c.jc & live;
    return m;
  endfunction

endpackage

// File: rtl/data_mem.sv
// Data memory: synchronous write, combinational read, no reset on contents.
module data_mem #(
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter int DW    = 8
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [DEPTH];

  // Write port commits on the rising edge.
  always_ff @(posedge clock) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  // Read sees contents before any same-cycle write.
  assign rdata = mem_q[addr];

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: data memory, jump resolution, wrong-path squash,
// and the MEM/WB pipeline register.
module mem_stage
  import cpu_pkg::*;
#(
  parameter int DEPTH        = 256,
  parameter int FLUSH_CYCLES = cpu_pkg::FLUSH_CYCLES
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       zeroIn,
  input  logic [7:0] acIn,
  input  logic [7:0] ulaJumpIn,
  input  logic [7:0] rsIn,
  input  logic       WRMem,
  input  logic       WMMem,
  input  logic       RMMem,
  input  logic       NEQMem,
  input  logic       JMem,
  input  logic       JCMem,
  output logic       pcSrc,
  output logic [7:0] jumpTarget,
  output logic       flush,
  output logic       WRWb,
  output logic       memToRegWb,
  output logic [7:0] memDataWb,
  output logic [7:0] acWb,
  output logic [7:0] rsWb
);

  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES);

  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic              wr_wb_q, wr_wb_d;
  logic              mem_to_reg_wb_q, mem_to_reg_wb_d;
  logic [DATA_W-1:0] mem_data_wb_q, mem_data_wb_d;
  logic [DATA_W-1:0] ac_wb_q, ac_wb_d;
  logic [DATA_W-1:0] rs_wb_q, rs_wb_d;

  ctrl_t             ctrl_raw;
  ctrl_t             ctrl;
  logic              live;
  logic              cond;
  logic              taken;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;

  // Bubble masking, branch decision and memory addressing.
  always_comb begin
    ctrl_raw = {WRMem, WMMem, RMMem, NEQMem, JMem, JCMem};
    live     = (flush_cnt_q == '0);
    ctrl     = mask_bubble(ctrl_raw, live);
    cond     = ctrl.neq ? ~zeroIn : zeroIn;
    taken    = ctrl.j | (ctrl.jc & cond);
    mem_addr = MEM_AW'(32'(rsIn) % DEPTH);
    // Reset overrides everything, including a store in flight.
    mem_we   = ctrl.wm & ~reset;
  end

  assign pcSrc      = taken;
  assign jumpTarget = ulaJumpIn;
  assign flush      = taken | (flush_cnt_q != '0);

  data_mem #(
    .DEPTH (DEPTH),
    .AW    (MEM_AW),
    .DW    (DATA_W)
  ) u_data_mem (
    .clock (clock),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (acIn),
    .rdata (mem_rdata)
  );

  // Next-state for the flush counter and MEM/WB register; capturing the
  // combinational read here gives old data when a store hits the same word.
  always_comb begin
    flush_cnt_d = flush_cnt_q;
    if (taken) begin
      flush_cnt_d = CNT_LOAD;
    end else if (flush_cnt_q != '0) begin
      flush_cnt_d = flush_cnt_q - 1'b1;
    end
    wr_wb_d         = ctrl.wr;
    mem_to_reg_wb_d = ctrl.rm;
    mem_data_wb_d   = ctrl.rm ? mem_rdata : '0;
    ac_wb_d         = acIn;
    rs_wb_d         = rsIn;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      flush_cnt_q     <= '0;
      wr_wb_q         <= 1'b0;
      mem_to_reg_wb_q <= 1'b0;
      mem_data_wb_q   <= '0;
      ac_wb_q         <= '0;
      rs_wb_q         <= '0;
    end else begin
      flush_cnt_q     <= flush_cnt_d;
      wr_wb_q         <= wr_wb_d;
      mem_to_reg_wb_q <= mem_to_reg_wb_d;
      mem_data_wb_q   <= mem_data_wb_d;
      ac_wb_q         <= ac_wb_d;
      rs_wb_q         <= rs_wb_d;
    end
  end

  assign WRWb       = wr_wb_q;
  assign memToRegWb = mem_to_reg_wb_q;
  assign memDataWb  = mem_data_wb_q;
  assign acWb       = ac_wb_q;
  assign rsWb       = rs_wb_q;

endmodule
